// File: rtl/uart_shift_feeder.sv
// Byte FIFO between uart_rx and shift_74hc595: queues received bytes and issues them
// one at a time as single-cycle rd_en pulses, each followed by a fixed guard gap.
module uart_shift_feeder #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 24,
    localparam int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           rx_data,
    input  logic                 received,
    input  logic                 clr_overflow,
    output logic [7:0]           data_out,
    output logic                 rd_en,
    output logic [ADDR_BITS:0]   level,
    output logic                 busy,
    output logic                 overflow
);

    localparam int TIMER_BITS = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [ADDR_BITS:0]    LEVEL_FULL = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [TIMER_BITS-1:0] TIMER_LOAD = TIMER_BITS'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                state;
    logic [TIMER_BITS-1:0] timer;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [7:0]            mem [DEPTH];

    logic pop;
    logic push_ok;
    logic drop;

    // A full FIFO still accepts a byte when the slot is being freed on the same edge.
    assign pop     = (state == S_IDLE) && (level != '0);
    assign push_ok = received && ((level < LEVEL_FULL) || pop);
    assign drop    = received && !push_ok;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            timer    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            data_out <= 8'h00;
            rd_en    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_BITS'(1);
            end
            if (push_ok && !pop) begin
                level <= level + (ADDR_BITS + 1)'(1);
            end else if (pop && !push_ok) begin
                level <= level - (ADDR_BITS + 1)'(1);
            end

            // A drop on the same edge as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    rd_en <= 1'b0;
                    if (pop) begin
                        data_out <= mem[rd_ptr];
                        rd_en    <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rd_en <= 1'b0;
                    timer <= TIMER_LOAD;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (timer == '0) begin
                        state <= S_IDLE;
                    end else begin
                        timer <= timer - TIMER_BITS'(1);
                    end
                end
                default: begin
                    rd_en <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
